hazard_stall_ctrl: RTL and testbench
====================================

HAZARD_STALL_CTRL -- requirements
Module: hazard_stall_ctrl

Interface
REQ-001 The block SHALL have parameter MD_LATENCY, default 32 (legal 2..63), giving mult/div result latency in cycles.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have ports id_rs and id_rt, input, 5 bits each: source registers of the instruction in IF/ID.
REQ-005 The block SHALL have port id_uses_rt, input, 1 bit: the ID instruction reads rt as a source.
REQ-006 The block SHALL have ports ex_rt (input, 5 bits) and ex_mem_read (input, 1 bit): load destination and load flag held in ID/EX.
REQ-007 The block SHALL have port branch_taken, input, 1 bit: branch resolved taken in ID this cycle.
REQ-008 The block SHALL have ports md_start (input, 1 bit: mult/div issued from EX) and id_reads_hilo (input, 1 bit: ID instruction is mfhi/mflo).
REQ-009 The block SHALL have ports pc_write and ifid_write, output, 1 bit each: 0 freezes PC and IF/ID.
REQ-010 The block SHALL have ports idex_bubble (output, 1 bit: zero ID/EX control fields) and ifid_flush (output, 1 bit: clear IF/ID to NOP).
REQ-011 The block SHALL have ports md_busy (output, 1 bit) and stall_cnt (output, 16 bits: total stall cycles since reset).

Function
REQ-012 load_hazard SHALL equal ex_mem_read AND ex_rt!=0 AND (ex_rt==id_rs OR (id_uses_rt AND ex_rt==id_rt)).
REQ-013 stall SHALL equal load_hazard OR md_hazard; while stall=1, pc_write=0, ifid_write=0, and idex_bubble=1, combinationally in the same cycle.
REQ-014 ifid_flush SHALL equal branch_taken AND NOT stall; a taken branch coincident with a stall SHALL be ignored, because ID re-evaluates it on the next cycle.
REQ-015 A load-use stall SHALL last exactly one cycle for a single load; back-to-back dependent loads SHALL each stall one cycle.
REQ-016 The state machine SHALL have states RUN and MD_WAIT.
REQ-017 RUN SHALL move to MD_WAIT when md_hazard=1; MD_WAIT SHALL return to RUN on the cycle md_cnt reaches 0.
REQ-018 md_cnt (6 bits) SHALL load MD_LATENCY-1 on md_start, otherwise decrement when nonzero; md_busy SHALL be (md_cnt!=0).
REQ-019 md_hazard SHALL equal id_reads_hilo AND md_busy.
REQ-020 md_start while busy SHALL reload md_cnt to MD_LATENCY-1, extending the wait.
REQ-021 stall_cnt SHALL increment by 1 on every clock edge where stall=1, and saturate at 16'hFFFF without wrap-around.

Reset
REQ-022 While rst=1, the outputs SHALL be pc_write=1, ifid_write=1, idex_bubble=0, ifid_flush=0, md_busy=0; after the edge, state=RUN, md_cnt=0, stall_cnt=0.
REQ-023 Reset asserted mid-MD_WAIT or mid-stall SHALL abandon the wait immediately, and the first cycle after reset SHALL behave as RUN with no history.

Configuration
REQ-024 With macro HAZARD_MULDIV_EN defined, the block SHALL implement REQ-016..REQ-020 as written.
REQ-025 Without HAZARD_MULDIV_EN, md_hazard, md_cnt and MD_WAIT SHALL be absent, md_busy SHALL tie to 0, md_start and id_reads_hilo SHALL be ignored, and only load-use stalls and branch flushes SHALL remain.

Verification
REQ-026 Scenario: ex_mem_read=1, ex_rt=8, id_rs=8 -> one cycle with pc_write=0, ifid_write=0, idex_bubble=1; stall_cnt becomes 1.
REQ-027 Scenario: ex_mem_read=1, ex_rt=0, id_rs=0 -> no stall, stall_cnt remains 0; and ex_rt=9, id_rt=9, id_uses_rt=0 -> no stall.
REQ-028 Scenario: branch_taken=1 with no hazard -> ifid_flush=1 for one cycle; branch_taken=1 with load_hazard=1 -> ifid_flush=0 and stall=1.
REQ-029 Scenario (HAZARD_MULDIV_EN, MD_LATENCY=4): md_start at cycle 0, id_reads_hilo=1 from cycle 1 -> stalls in cycles 1..3, release in cycle 4, stall_cnt=3.
REQ-030 Scenario: rst asserted in the second cycle of MD_WAIT -> outputs at reset values that cycle; next cycle md_busy=0, stall=0, stall_cnt=0.
REQ-031 Scenario: force 65537 stall cycles -> stall_cnt reads 16'hFFFF and holds.

Source files
------------

// File: rtl/hazard_stall_ctrl.sv
// Pipeline hazard unit: load-use stalls, branch flush, optional mult/div result wait.
// Define HAZARD_MULDIV_EN to enable the HI/LO read interlock (md_busy tied low otherwise).
module hazard_stall_ctrl #(
    parameter int unsigned MD_LATENCY = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic        id_uses_rt,
    input  logic [4:0]  ex_rt,
    input  logic        ex_mem_read,
    input  logic        branch_taken,
    input  logic        md_start,
    input  logic        id_reads_hilo,
    output logic        pc_write,
    output logic        ifid_write,
    output logic        idex_bubble,
    output logic        ifid_flush,
    output logic        md_busy,
    output logic [15:0] stall_cnt
);

    logic        load_hazard;
    logic        md_hazard;
    logic        md_busy_raw;
    logic        stall;
    logic [15:0] stall_cnt_q, stall_cnt_d;

    assign load_hazard = ex_mem_read && (ex_rt != 5'd0) &&
                         ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));

`ifdef HAZARD_MULDIV_EN
    typedef enum logic {
        RUN,
        MD_WAIT
    } state_e;

    localparam logic [5:0] MD_RELOAD = 6'(MD_LATENCY - 1);

    state_e     state_q, state_d;
    logic [5:0] md_cnt_q, md_cnt_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= RUN;
            md_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            md_cnt_q <= md_cnt_d;
        end
    end

    // A new issue always restarts the countdown, even mid-wait.
    always_comb begin
        md_cnt_d = md_cnt_q;
        if (md_start) begin
            md_cnt_d = MD_RELOAD;
        end else if (md_cnt_q != '0) begin
            md_cnt_d = md_cnt_q - 6'd1;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:     if (md_hazard) state_d = MD_WAIT;
            MD_WAIT: if (md_cnt_q == '0) state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    assign md_busy_raw = (md_cnt_q != '0);
    assign md_hazard   = id_reads_hilo && md_busy_raw;
`else
    localparam int unsigned md_latency_unused = MD_LATENCY;
    logic md_inputs_unused;

    assign md_inputs_unused = md_start ^ id_reads_hilo;
    assign md_busy_raw      = 1'b0;
    assign md_hazard        = 1'b0;
`endif

    // Reset masks every control output so the pipeline runs freely while held.
    assign stall = (load_hazard || md_hazard) && !rst;

    always_comb begin
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        idex_bubble = 1'b0;
        ifid_flush  = 1'b0;
        md_busy     = md_busy_raw && !rst;
        if (stall) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_bubble = 1'b1;
        end else if (!rst) begin
            ifid_flush = branch_taken;
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Scoreboard bench for hazard_stall_ctrl; mult/div scenarios run only with HAZARD_MULDIV_EN.
module tb_hazard_stall_ctrl;

    localparam int unsigned LAT = 4;
`ifdef HAZARD_MULDIV_EN
    localparam bit MD_EN = 1'b1;
`else
    localparam bit MD_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  id_rs, id_rt, ex_rt;
    logic        id_uses_rt, ex_mem_read, branch_taken, md_start, id_reads_hilo;
    logic        pc_write, ifid_write, idex_bubble, ifid_flush, md_busy;
    logic [15:0] stall_cnt;

    always #5 clk = ~clk;

    hazard_stall_ctrl #(.MD_LATENCY(LAT)) dut (
        .clk           (clk),
        .rst           (rst),
        .id_rs         (id_rs),
        .id_rt         (id_rt),
        .id_uses_rt    (id_uses_rt),
        .ex_rt         (ex_rt),
        .ex_mem_read   (ex_mem_read),
        .branch_taken  (branch_taken),
        .md_start      (md_start),
        .id_reads_hilo (id_reads_hilo),
        .pc_write      (pc_write),
        .ifid_write    (ifid_write),
        .idex_bubble   (idex_bubble),
        .ifid_flush    (ifid_flush),
        .md_busy       (md_busy),
        .stall_cnt     (stall_cnt)
    );

    typedef struct {
        string       tag;
        logic [20:0] exp;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   failures = 0;
    int   m_md = 0;
    int   m_sc = 0;

    task automatic check(input string tag, input logic [20:0] got, input logic [20:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got={pc,ifw,bub,flush,busy,cnt}=%b_%h want=%b_%h", tag,
                     got[20:16], got[15:0], exp[20:16], exp[15:0]);
        end
    endtask

    // One clock cycle: drive, predict, sample mid-cycle, then advance the model past the edge.
    task automatic cyc(input string tag, input logic r, input logic [4:0] rs, input logic [4:0] rt,
                       input logic uses, input logic [4:0] ert, input logic mr, input logic br,
                       input logic ms, input logic hl);
        exp_t e;
        exp_t s;
        bit   lh, busy, stl;
        rst = r; id_rs = rs; id_rt = rt; id_uses_rt = uses; ex_rt = ert;
        ex_mem_read = mr; branch_taken = br; md_start = ms; id_reads_hilo = hl;
        lh   = mr && (ert != 0) && ((ert == rs) || (uses && (ert == rt)));
        busy = MD_EN && (m_md != 0) && !r;
        stl  = (lh || (hl && busy)) && !r;
        e.tag = tag;
        e.exp = {!stl, !stl, stl, br && !stl && !r, busy, 16'(m_sc)};
        q.push_back(e);
        #4;
        s = q.pop_front();
        check(s.tag, {pc_write, ifid_write, idex_bubble, ifid_flush, md_busy, stall_cnt}, s.exp);
        if (r) begin
            m_md = 0;
            m_sc = 0;
        end else begin
            if (stl && m_sc != 65535) m_sc++;
            if (MD_EN) begin
                if (ms) m_md = LAT - 1;
                else if (m_md != 0) m_md--;
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; id_rs = '0; id_rt = '0; id_uses_rt = 1'b0; ex_rt = '0;
        ex_mem_read = 1'b0; branch_taken = 1'b0; md_start = 1'b0; id_reads_hilo = 1'b0;
        @(posedge clk);
        #1;
        cyc("reset_hold",   1, 8, 0, 0, 8, 1, 1, 0, 0);
        cyc("idle",         0, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc("lu_rs_stall",  0, 8, 3, 0, 8, 1, 0, 0, 0);
        cyc("lu_rs_after",  0, 8, 3, 0, 8, 0, 0, 0, 0);
        cyc("r0_no_stall",  0, 0, 0, 1, 0, 1, 0, 0, 0);
        cyc("rt_unused",    0, 1, 9, 0, 9, 1, 0, 0, 0);
        cyc("rt_used",      0, 1, 9, 1, 9, 1, 0, 0, 0);
        cyc("b2b_load1",    0, 4, 5, 1, 4, 1, 0, 0, 0);
        cyc("b2b_load2",    0, 4, 5, 1, 5, 1, 0, 0, 0);
        cyc("no_dep_load",  0, 4, 5, 1, 6, 1, 0, 0, 0);
        cyc("br_flush",     0, 2, 3, 1, 7, 1, 1, 0, 0);
        cyc("br_flush_end", 0, 2, 3, 1, 7, 1, 0, 0, 0);
        cyc("br_vs_stall",  0, 7, 3, 1, 7, 1, 1, 0, 0);
        cyc("md_issue",     0, 0, 0, 0, 0, 0, 0, 1, 0);
        for (int i = 1; i <= 4; i++) cyc($sformatf("md_wait_c%0d", i), 0, 0, 0, 0, 0, 0, 0, 0, 1);
        cyc("md_idle",      0, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc("md_issue2",    0, 0, 0, 0, 0, 0, 0, 1, 0);
        cyc("md_hilo",      0, 0, 0, 0, 0, 0, 0, 0, 1);
        cyc("md_reload",    0, 0, 0, 0, 0, 0, 0, 1, 1);
        for (int i = 0; i < 5; i++) cyc($sformatf("md_ext_%0d", i), 0, 0, 0, 0, 0, 0, 1, 0, 1);
        cyc("md_issue3",    0, 0, 0, 0, 0, 0, 0, 1, 0);
        cyc("md_wait1",     0, 0, 0, 0, 0, 0, 0, 0, 1);
        cyc("md_rst_wait",  1, 0, 0, 0, 0, 0, 1, 0, 1);
        cyc("post_rst",     0, 0, 0, 0, 0, 0, 0, 0, 1);
        cyc("post_rst2",    0, 0, 0, 0, 0, 0, 1, 0, 1);
        for (int i = 0; i < 300; i++) begin
            cyc("rand", ($urandom_range(0, 40) == 0), 5'($urandom_range(0, 3)),
                5'($urandom_range(0, 3)), 1'($urandom), 5'($urandom_range(0, 3)),
                1'($urandom), 1'($urandom), ($urandom_range(0, 7) == 0), 1'($urandom));
        end
        cyc("sat_reset",    1, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 65537; i++) cyc("sat_run", 0, 8, 0, 0, 8, 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) cyc("sat_hold", 0, 8, 0, 0, 8, 1, 0, 0, 0);
        cyc("sat_idle",     0, 0, 0, 0, 0, 0, 0, 0, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout got=running want=finished");
        $fatal(1, "simulation time limit");
    end

endmodule
